// File: rtl/axil_if.sv
// AXI4-Lite signal bundle. N lanes are packed side by side so the same bundle
// serves the single upstream port (N = 1) and the fanned-out slave side.
interface axil_if #(
  parameter int N          = 1,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  localparam int STRB_WIDTH = DATA_WIDTH / 8;

  logic [N*ADDR_WIDTH-1:0] araddr;
  logic [N-1:0]            arvalid;
  logic [N-1:0]            arready;
  logic [N*DATA_WIDTH-1:0] rdata;
  logic [N*2-1:0]          rresp;
  logic [N-1:0]            rvalid;
  logic [N-1:0]            rready;
  logic [N*ADDR_WIDTH-1:0] awaddr;
  logic [N-1:0]            awvalid;
  logic [N-1:0]            awready;
  logic [N*DATA_WIDTH-1:0] wdata;
  logic [N*STRB_WIDTH-1:0] wstrb;
  logic [N-1:0]            wvalid;
  logic [N-1:0]            wready;
  logic [N*2-1:0]          bresp;
  logic [N-1:0]            bvalid;
  logic [N-1:0]            bready;

  modport master (
    output araddr, arvalid, input arready,
    input  rdata, rresp, rvalid, output rready,
    output awaddr, awvalid, input awready,
    output wdata, wstrb, wvalid, input wready,
    input  bresp, bvalid, output bready
  );

  modport slave (
    input  araddr, arvalid, output arready,
    output rdata, rresp, rvalid, input rready,
    input  awaddr, awvalid, output awready,
    input  wdata, wstrb, wvalid, output wready,
    output bresp, bvalid, input bready
  );
endinterface

// File: rtl/axil_interconnect_1xn.sv
// AXI4-Lite 1-to-N interconnect: one transaction in flight, base/mask address
// decode (lowest index wins), DECERR for unmapped addresses, and round-robin
// choice between a pending read and a pending write.
module axil_interconnect_1xn #(
  parameter int NUM_SLAVES = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter logic [NUM_SLAVES*ADDR_WIDTH-1:0] BASE_ADDRS = {(NUM_SLAVES*ADDR_WIDTH){1'b0}},
  parameter logic [NUM_SLAVES*ADDR_WIDTH-1:0] ADDR_MASKS = {(NUM_SLAVES*ADDR_WIDTH){1'b0}}
) (
  input  logic  clk_i,
  input  logic  rst_i,
  axil_if.slave  s_axi,
  axil_if.master m_axi
);
  localparam int STRB_WIDTH = DATA_WIDTH / 8;
  localparam int IDX_W      = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    RD_ADDR   = 3'd1,
    RD_DATA   = 3'd2,
    RD_DECERR = 3'd3,
    WR_ADDR   = 3'd4,
    WR_RESP   = 3'd5,
    WR_DECERR = 3'd6
  } state_t;

  state_t                  state_r, state_nxt_s;
  logic                    last_wr_r;
  logic                    aw_done_r, w_done_r;
  logic [ADDR_WIDTH-1:0]   addr_r;
  logic [DATA_WIDTH-1:0]   wdata_r;
  logic [STRB_WIDTH-1:0]   wstrb_r;
  logic [IDX_W-1:0]        idx_r;
  logic [IDX_W:0]          rd_dec_s, wr_dec_s;
  logic                    rd_cand_s, wr_cand_s, grant_rd_s, grant_wr_s;
  logic                    aw_hs_s, w_hs_s, aw_fin_s, w_fin_s;

  // Result is {hit, index}; scanning downward lets the lowest matching slave win.
  function automatic logic [IDX_W:0] decode(input logic [ADDR_WIDTH-1:0] addr);
    logic [IDX_W:0] res;
    res = {(IDX_W+1){1'b0}};
    for (int k = NUM_SLAVES - 1; k >= 0; k--) begin
      res = ((addr & ADDR_MASKS[k*ADDR_WIDTH +: ADDR_WIDTH]) == BASE_ADDRS[k*ADDR_WIDTH +: ADDR_WIDTH])
            ? {1'b1, IDX_W'(k)} : res;
    end
    return res;
  endfunction

  assign rd_dec_s   = decode(s_axi.araddr);
  assign wr_dec_s   = decode(s_axi.awaddr);
  assign rd_cand_s  = s_axi.arvalid[0];
  assign wr_cand_s  = s_axi.awvalid[0] & s_axi.wvalid[0];
  // On a tie the type that did not win last time is granted.
  assign grant_rd_s = (state_r == IDLE) & rd_cand_s & (~wr_cand_s | last_wr_r);
  assign grant_wr_s = (state_r == IDLE) & wr_cand_s & (~rd_cand_s | ~last_wr_r);
  assign aw_hs_s    = (state_r == WR_ADDR) & ~aw_done_r & m_axi.awready[idx_r];
  assign w_hs_s     = (state_r == WR_ADDR) & ~w_done_r & m_axi.wready[idx_r];
  assign aw_fin_s   = aw_done_r | aw_hs_s;
  assign w_fin_s    = w_done_r | w_hs_s;

  // Address, data and strobe are broadcast; only the valids select a slave.
  assign m_axi.araddr = {NUM_SLAVES{addr_r}};
  assign m_axi.awaddr = {NUM_SLAVES{addr_r}};
  assign m_axi.wdata  = {NUM_SLAVES{wdata_r}};
  assign m_axi.wstrb  = {NUM_SLAVES{wstrb_r}};

  // State, grant history, captured request and per-channel write completion.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_r   <= IDLE;
      last_wr_r <= 1'b1;
      aw_done_r <= 1'b0;
      w_done_r  <= 1'b0;
      addr_r    <= {ADDR_WIDTH{1'b0}};
      wdata_r   <= {DATA_WIDTH{1'b0}};
      wstrb_r   <= {STRB_WIDTH{1'b0}};
      idx_r     <= {IDX_W{1'b0}};
    end else begin
      state_r   <= state_nxt_s;
      aw_done_r <= (state_nxt_s == WR_ADDR) & aw_fin_s;
      w_done_r  <= (state_nxt_s == WR_ADDR) & w_fin_s;
      if (grant_rd_s) begin
        addr_r    <= s_axi.araddr;
        idx_r     <= rd_dec_s[IDX_W-1:0];
        last_wr_r <= 1'b0;
      end else if (grant_wr_s) begin
        addr_r    <= s_axi.awaddr;
        wdata_r   <= s_axi.wdata;
        wstrb_r   <= s_axi.wstrb;
        idx_r     <= wr_dec_s[IDX_W-1:0];
        last_wr_r <= 1'b1;
      end
    end
  end

  // Next-state selection from the grant and the downstream/upstream handshakes.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (grant_rd_s) begin
          state_nxt_s = rd_dec_s[IDX_W] ? RD_ADDR : RD_DECERR;
        end else if (grant_wr_s) begin
          state_nxt_s = wr_dec_s[IDX_W] ? WR_ADDR : WR_DECERR;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      RD_ADDR:   state_nxt_s = m_axi.arready[idx_r] ? RD_DATA : RD_ADDR;
      RD_DATA:   state_nxt_s = (m_axi.rvalid[idx_r] & s_axi.rready[0]) ? IDLE : RD_DATA;
      RD_DECERR: state_nxt_s = s_axi.rready[0] ? IDLE : RD_DECERR;
      WR_ADDR:   state_nxt_s = (aw_fin_s & w_fin_s) ? WR_RESP : WR_ADDR;
      WR_RESP:   state_nxt_s = (m_axi.bvalid[idx_r] & s_axi.bready[0]) ? IDLE : WR_RESP;
      WR_DECERR: state_nxt_s = s_axi.bready[0] ? IDLE : WR_DECERR;
      default:   state_nxt_s = IDLE;
    endcase
  end

  // Handshake outputs; everything is held low while reset is asserted.
  always_comb begin
    s_axi.arready = 1'b0;
    s_axi.awready = 1'b0;
    s_axi.wready  = 1'b0;
    s_axi.rvalid  = 1'b0;
    s_axi.rdata   = {DATA_WIDTH{1'b0}};
    s_axi.rresp   = 2'b00;
    s_axi.bvalid  = 1'b0;
    s_axi.bresp   = 2'b00;
    m_axi.arvalid = {NUM_SLAVES{1'b0}};
    m_axi.rready  = {NUM_SLAVES{1'b0}};
    m_axi.awvalid = {NUM_SLAVES{1'b0}};
    m_axi.wvalid  = {NUM_SLAVES{1'b0}};
    m_axi.bready  = {NUM_SLAVES{1'b0}};
    if (!rst_i) begin
      case (state_r)
        IDLE: begin
          s_axi.arready = grant_rd_s;
          s_axi.awready = grant_wr_s;
          s_axi.wready  = grant_wr_s;
        end
        RD_ADDR: m_axi.arvalid[idx_r] = 1'b1;
        RD_DATA: begin
          s_axi.rvalid        = m_axi.rvalid[idx_r];
          s_axi.rdata         = m_axi.rdata[idx_r*DATA_WIDTH +: DATA_WIDTH];
          s_axi.rresp         = m_axi.rresp[idx_r*2 +: 2];
          m_axi.rready[idx_r] = s_axi.rready[0];
        end
        RD_DECERR: begin
          s_axi.rvalid = 1'b1;
          s_axi.rresp  = 2'b11;
        end
        WR_ADDR: begin
          m_axi.awvalid[idx_r] = ~aw_done_r;
          m_axi.wvalid[idx_r]  = ~w_done_r;
        end
        WR_RESP: begin
          s_axi.bvalid        = m_axi.bvalid[idx_r];
          s_axi.bresp         = m_axi.bresp[idx_r*2 +: 2];
          m_axi.bready[idx_r] = s_axi.bready[0];
        end
        WR_DECERR: begin
          s_axi.bvalid = 1'b1;
          s_axi.bresp  = 2'b11;
        end
        default: begin
          s_axi.rvalid = 1'b0;
        end
      endcase
    end else begin
      s_axi.bvalid = 1'b0;
    end
  end
endmodule

// File: tb/tb_axil_interconnect_1xn.sv
// Randomized bench for axil_interconnect_1xn: random slave timing, reference
// decode/arbitration model, plus directed reset, DECERR, overlap and split cases.
module tb_axil_interconnect_1xn;
  localparam int NS = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  axil_if #(.N(1),  .ADDR_WIDTH(32), .DATA_WIDTH(32)) up ();
  axil_if #(.N(NS), .ADDR_WIDTH(32), .DATA_WIDTH(32)) dn ();

  axil_interconnect_1xn #(
    .NUM_SLAVES(NS), .ADDR_WIDTH(32), .DATA_WIDTH(32),
    .BASE_ADDRS({32'h2000_0000, 32'h3000_0000, 32'h1000_0000, 32'h2000_0000}),
    .ADDR_MASKS({32'hF000_0000, 32'hF000_0000, 32'hF000_0000, 32'hFF00_0000})
  ) dut (
    .clk_i(clk), .rst_i(rst), .s_axi(up), .m_axi(dn)
  );

  // Reference address map (slave 0 and 3 overlap on 0x20xx_xxxx)
  logic [31:0] ref_base [NS] = '{32'h2000_0000, 32'h1000_0000, 32'h3000_0000, 32'h2000_0000};
  logic [31:0] ref_mask [NS] = '{32'hFF00_0000, 32'hF000_0000, 32'hF000_0000, 32'hF000_0000};

  int n_tests = 0;
  int n_fail  = 0;
  int model_last_wr = 1;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic int ref_decode(input logic [31:0] a);
    for (int k = 0; k < NS; k++) begin
      if ((a & ref_mask[k]) == ref_base[k]) return k;
    end
    return -1;
  endfunction

  function automatic logic [31:0] slv_data(input int k, input logic [31:0] a);
    return a ^ (32'hA5A5_0000 | (k * 32'h0000_0101));
  endfunction

  function automatic logic [1:0] slv_resp(input logic [31:0] a);
    return a[3] ? 2'b10 : 2'b00;
  endfunction

  function automatic logic [31:0] rand_addr();
    logic [7:0] his [8] = '{8'h10, 8'h1F, 8'h20, 8'h21, 8'h2F, 8'h30, 8'h90, 8'hC5};
    logic [23:0] lo;
    lo = 24'($urandom) & 24'hFF_FFFC;
    return {his[$urandom_range(7)], lo};
  endfunction

  // ---------------- slave models ----------------
  bit          stall_aw = 1'b0;
  bit          rd_pend [NS];
  bit          aw_got  [NS];
  bit          w_got   [NS];
  bit          f_r     [NS];
  bit          f_b     [NS];
  bit          rst_now;
  logic [31:0] rd_addr    [NS];
  logic [31:0] cap_awaddr [NS];
  logic [31:0] cap_wdata  [NS];
  logic [3:0]  cap_wstrb  [NS];
  int          rd_cnt [NS];
  int          wr_cnt [NS];

  function automatic int sum_cnt(input bit wr);
    int s = 0;
    for (int k = 0; k < NS; k++) s += wr ? wr_cnt[k] : rd_cnt[k];
    return s;
  endfunction

  initial begin
    rst_now = 1'b1;
    for (int k = 0; k < NS; k++) begin
      rd_pend[k] = 1'b0; aw_got[k] = 1'b0; w_got[k] = 1'b0; f_r[k] = 1'b0; f_b[k] = 1'b0;
      rd_cnt[k] = 0; wr_cnt[k] = 0;
    end
    dn.arready = '0; dn.rvalid = '0; dn.rdata = '0; dn.rresp = '0;
    dn.awready = '0; dn.wready = '0; dn.bvalid = '0; dn.bresp = '0;
    forever begin
      @(negedge clk);
      for (int k = 0; k < NS; k++) begin
        if (rst_now) begin
          rd_pend[k] = 1'b0; aw_got[k] = 1'b0; w_got[k] = 1'b0;
          dn.rvalid[k] = 1'b0; dn.bvalid[k] = 1'b0;
        end else begin
          if (f_r[k]) dn.rvalid[k] = 1'b0;
          if (f_b[k]) dn.bvalid[k] = 1'b0;
          if (rd_pend[k] && !dn.rvalid[k] && $urandom_range(1) == 1) begin
            dn.rvalid[k] = 1'b1;
            dn.rdata[k*32 +: 32] = slv_data(k, rd_addr[k]);
            dn.rresp[k*2 +: 2]   = slv_resp(rd_addr[k]);
            rd_pend[k] = 1'b0;
          end
          if (aw_got[k] && w_got[k] && !dn.bvalid[k] && $urandom_range(1) == 1) begin
            dn.bvalid[k] = 1'b1;
            dn.bresp[k*2 +: 2] = slv_resp(cap_awaddr[k]);
            aw_got[k] = 1'b0; w_got[k] = 1'b0;
            wr_cnt[k]++;
          end
        end
        dn.arready[k] = 1'($urandom_range(1));
        dn.awready[k] = stall_aw ? 1'b0 : 1'($urandom_range(1));
        dn.wready[k]  = stall_aw ? 1'b1 : 1'($urandom_range(1));
      end
      #1;
      rst_now = rst;
      for (int k = 0; k < NS; k++) begin
        f_r[k] = dn.rvalid[k] & dn.rready[k];
        f_b[k] = dn.bvalid[k] & dn.bready[k];
        if (aw_got[k]) check_eq("aw_drop_after_hs", dn.awvalid[k], 1'b0);
        if (w_got[k])  check_eq("w_drop_after_hs", dn.wvalid[k], 1'b0);
        if (dn.arvalid[k] && dn.arready[k]) begin
          rd_pend[k] = 1'b1; rd_addr[k] = dn.araddr[k*32 +: 32]; rd_cnt[k]++;
        end
        if (dn.awvalid[k] && dn.awready[k]) begin
          aw_got[k] = 1'b1; cap_awaddr[k] = dn.awaddr[k*32 +: 32];
        end
        if (dn.wvalid[k] && dn.wready[k]) begin
          w_got[k] = 1'b1; cap_wdata[k] = dn.wdata[k*32 +: 32]; cap_wstrb[k] = dn.wstrb[k*4 +: 4];
        end
      end
    end
  end

  // ---------------- upstream transaction driver + reference checks ----------------
  task automatic run_pair(input bit do_rd, input logic [31:0] ra, input bit do_wr,
                          input logic [31:0] wa, input logic [31:0] wd, input logic [3:0] ws);
    int tr = ref_decode(ra);
    int tw = ref_decode(wa);
    int rc_t = (tr >= 0) ? rd_cnt[tr] : 0;
    int wc_t = (tw >= 0) ? wr_cnt[tw] : 0;
    int rt0 = sum_cnt(1'b0);
    int wt0 = sum_cnt(1'b1);
    bit rd_open = do_rd;
    bit wr_open = do_wr;
    bit ar_hs, aw_hs, rv_seen = 1'b0, bv_seen = 1'b0;
    int ar_cyc = -1, aw_cyc = -1, first = -1, cyc = 0;
    int exp_first = (model_last_wr != 0) ? 0 : 1;
    logic [NS-1:0] rmask = '0;
    logic [NS-1:0] wmask = '0;
    if (do_rd && tr >= 0) rmask[tr] = 1'b1;
    if (do_wr && tw >= 0) wmask[tw] = 1'b1;
    @(negedge clk);
    up.araddr = ra; up.arvalid = do_rd;
    up.awaddr = wa; up.wdata = wd; up.wstrb = ws;
    up.awvalid = do_wr; up.wvalid = do_wr;
    while ((rd_open || wr_open) && cyc < 400) begin
      up.rready = ($urandom_range(3) != 0);
      up.bready = ($urandom_range(3) != 0);
      #1;
      check_eq("ar_aw_ready_excl", up.arready & up.awready, 1'b0);
      check_eq("rd_chan_onehot", (dn.arvalid | dn.rready) & ~rmask, '0);
      check_eq("wr_chan_onehot", (dn.awvalid | dn.wvalid | dn.bready) & ~wmask, '0);
      ar_hs = up.arvalid[0] & up.arready[0];
      aw_hs = up.awvalid[0] & up.awready[0];
      if (ar_hs) begin ar_cyc = cyc; if (first < 0) first = 0; end
      if (aw_hs) begin
        check_eq("aw_w_ready_together", up.wready, 1'b1);
        aw_cyc = cyc; if (first < 0) first = 1;
      end
      if (rd_open && up.rvalid[0]) begin
        if (!rv_seen && tr < 0) check_eq("decerr_r_latency", cyc - ar_cyc, 1);
        if (tr >= 0) check_eq("r_valid_passthru", dn.rvalid[tr], 1'b1);
        rv_seen = 1'b1;
        if (up.rready[0]) begin
          check_eq("rdata", up.rdata, (tr < 0) ? 32'h0 : slv_data(tr, ra));
          check_eq("rresp", up.rresp, (tr < 0) ? 2'b11 : slv_resp(ra));
          rd_open = 1'b0;
        end
      end
      if (wr_open && up.bvalid[0]) begin
        if (!bv_seen && tw < 0) check_eq("decerr_b_latency", cyc - aw_cyc, 1);
        if (tw >= 0) check_eq("b_after_slave_b", dn.bvalid[tw], 1'b1);
        bv_seen = 1'b1;
        if (up.bready[0]) begin
          check_eq("bresp", up.bresp, (tw < 0) ? 2'b11 : slv_resp(wa));
          wr_open = 1'b0;
        end
      end
      @(negedge clk);
      cyc++;
      if (ar_hs) up.arvalid = 1'b0;
      if (aw_hs) begin up.awvalid = 1'b0; up.wvalid = 1'b0; end
    end
    check_eq("txn_timeout", {rd_open, wr_open}, 2'b00);
    up.arvalid = 1'b0; up.awvalid = 1'b0; up.wvalid = 1'b0;
    if (do_rd && do_wr) begin
      check_eq("grant_first", first, exp_first);
      model_last_wr = (exp_first == 0) ? 1 : 0;
    end else begin
      model_last_wr = do_wr ? 1 : 0;
    end
    if (do_rd) begin
      if (tr >= 0) check_eq("rd_slave_hit", rd_cnt[tr] - rc_t, 1);
      else         check_eq("rd_decerr_quiet", sum_cnt(1'b0) - rt0, 0);
    end
    if (do_wr) begin
      if (tw >= 0) begin
        check_eq("wr_slave_hit", wr_cnt[tw] - wc_t, 1);
        check_eq("wr_addr", cap_awaddr[tw], wa);
        check_eq("wr_data", cap_wdata[tw], wd);
        check_eq("wr_strb", cap_wstrb[tw], ws);
      end else begin
        check_eq("wr_decerr_quiet", sum_cnt(1'b1) - wt0, 0);
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    up.araddr = '0; up.arvalid = 1'b1; up.rready = 1'b1;
    up.awaddr = '0; up.awvalid = 1'b1; up.wdata = '0; up.wstrb = '0; up.wvalid = 1'b1;
    up.bready = 1'b1;

    // Outputs held low under reset even with upstream valids present
    repeat (2) @(negedge clk);
    #1;
    check_eq("rst_arready", up.arready, 1'b0);
    check_eq("rst_awready", up.awready, 1'b0);
    check_eq("rst_wready", up.wready, 1'b0);
    check_eq("rst_rvalid", up.rvalid, 1'b0);
    check_eq("rst_bvalid", up.bvalid, 1'b0);
    check_eq("rst_rdata_resp", {up.rdata, up.rresp, up.bresp}, '0);
    check_eq("rst_m_valids", {dn.arvalid, dn.awvalid, dn.wvalid, dn.rready, dn.bready}, '0);

    // AW without W is not a write candidate
    @(negedge clk);
    rst = 1'b0; up.arvalid = 1'b0; up.wvalid = 1'b0; up.awaddr = 32'h1000_0000;
    for (int i = 0; i < 3; i++) begin
      #1;
      check_eq("aw_only_no_grant", up.awready, 1'b0);
      check_eq("aw_only_no_m_valid", dn.awvalid, '0);
      @(negedge clk);
    end
    up.awvalid = 1'b0;

    // Round-robin: simultaneous read/write twice -> R, W, R, W
    run_pair(1'b1, 32'h1000_0004, 1'b1, 32'h3000_0008, 32'h1234_5678, 4'hF);
    run_pair(1'b1, 32'h3000_0100, 1'b1, 32'h1000_0200, 32'hCAFE_F00D, 4'h3);
    // Single read, DECERR read and write, overlapping map
    run_pair(1'b1, 32'h1000_0004, 1'b0, 32'h0, 32'h0, 4'h0);
    run_pair(1'b1, 32'h9000_0000, 1'b0, 32'h0, 32'h0, 4'h0);
    run_pair(1'b0, 32'h0, 1'b1, 32'h9000_0000, 32'h5555_AAAA, 4'hF);
    run_pair(1'b1, 32'h2000_0000, 1'b1, 32'h2100_0010, 32'h0BAD_BEEF, 4'hC);

    // Split completion: W handshakes while AW stays stalled
    stall_aw = 1'b1;
    fork
      run_pair(1'b0, 32'h0, 1'b1, 32'h3000_0040, 32'hA1B2_C3D4, 4'h5);
      begin
        repeat (4) @(negedge clk);
        #2;
        check_eq("split_aw_held", dn.awvalid[2], 1'b1);
        check_eq("split_w_dropped", dn.wvalid[2], 1'b0);
        check_eq("split_no_b_yet", up.bvalid, 1'b0);
        stall_aw = 1'b0;
      end
    join

    // Reset in the middle of a write
    stall_aw = 1'b1;
    @(negedge clk);
    up.awaddr = 32'h3000_0010; up.wdata = 32'h1111_2222; up.wstrb = 4'hF;
    up.awvalid = 1'b1; up.wvalid = 1'b1; up.bready = 1'b1;
    #1;
    check_eq("rstw_accept", up.awready, 1'b1);
    @(negedge clk);
    up.awvalid = 1'b0; up.wvalid = 1'b0;
    @(negedge clk);
    #1;
    check_eq("rstw_in_wr_addr", dn.awvalid[2], 1'b1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_eq("rstw_valids_in_rst", {dn.awvalid, dn.wvalid}, '0);
    @(negedge clk);
    rst = 1'b0; stall_aw = 1'b0; model_last_wr = 1;
    #1;
    check_eq("rstw_valids_after", {dn.awvalid, dn.wvalid, dn.arvalid}, '0);
    check_eq("rstw_no_b", up.bvalid, 1'b0);
    run_pair(1'b1, 32'h1000_0040, 1'b0, 32'h0, 32'h0, 4'h0);

    // Randomized traffic
    for (int i = 0; i < 80; i++) begin
      int kind;
      kind = $urandom_range(2);
      run_pair(kind != 1, rand_addr(), kind != 0, rand_addr(), $urandom, 4'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
